// File: rtl/a51_pkg.sv
// A5/1 shared definitions: FSM states, LFSR step modes, register geometry,
// feedback tap masks, clock-bit positions and setup phase lengths.
package a51_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_FRAME,
        WARMUP,
        GEN,
        XFER,
        DONE
    } a51_state_t;

    // How the three registers advance this cycle.
    typedef enum logic [1:0] {
        MODE_HOLD,
        MODE_LOAD,
        MODE_MAJ
    } lfsr_mode_t;

    localparam int R1_LEN = 19;
    localparam int R2_LEN = 22;
    localparam int R3_LEN = 23;

    // Feedback taps as masks: R1 18,17,16,13; R2 21,20; R3 22,21,20,7.
    localparam logic [R1_LEN-1:0] R1_TAPS = 19'h72000;
    localparam logic [R2_LEN-1:0] R2_TAPS = 22'h300000;
    localparam logic [R3_LEN-1:0] R3_TAPS = 23'h700080;

    localparam int R1_CLK = 8;
    localparam int R2_CLK = 10;
    localparam int R3_CLK = 10;

    localparam int KEY_BITS   = 64;
    localparam int FRAME_BITS = 22;
    localparam int GEN_BITS   = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/a51_lfsr_core.sv
// A5/1 register core: R1/R2/R3 with load (all clock, bit injected) and
// majority-clocked stepping. ks_bit is the output function of the state the
// registers will hold after this cycle's step, so it can be captured alongside it.
module a51_lfsr_core
    import a51_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  lfsr_mode_t mode,
    input  logic       load_bit,
    output logic       ks_bit
);

    logic [R1_LEN-1:0] r1_reg, r1_next;
    logic [R2_LEN-1:0] r2_reg, r2_next;
    logic [R3_LEN-1:0] r3_reg, r3_next;
    logic              fb1, fb2, fb3;
    logic              maj_bit;

    assign fb1     = ^(r1_reg & R1_TAPS);
    assign fb2     = ^(r2_reg & R2_TAPS);
    assign fb3     = ^(r3_reg & R3_TAPS);
    assign maj_bit = maj3(r1_reg[R1_CLK], r2_reg[R2_CLK], r3_reg[R3_CLK]);

    // Next register contents for the requested step mode.
    always_comb begin
        r1_next = r1_reg;
        r2_next = r2_reg;
        r3_next = r3_reg;
        case (mode)
            MODE_LOAD: begin
                r1_next = {r1_reg[R1_LEN-2:0], fb1 ^ load_bit};
                r2_next = {r2_reg[R2_LEN-2:0], fb2 ^ load_bit};
                r3_next = {r3_reg[R3_LEN-2:0], fb3 ^ load_bit};
            end
            MODE_MAJ: begin
                if (r1_reg[R1_CLK] == maj_bit) r1_next = {r1_reg[R1_LEN-2:0], fb1};
                if (r2_reg[R2_CLK] == maj_bit) r2_next = {r2_reg[R2_LEN-2:0], fb2};
                if (r3_reg[R3_CLK] == maj_bit) r3_next = {r3_reg[R3_LEN-2:0], fb3};
            end
            default: ;
        endcase
    end

    assign ks_bit = r1_next[R1_LEN-1] ^ r2_next[R2_LEN-1] ^ r3_next[R3_LEN-1];

    // Register state; clear zeroes all three at the start of key setup.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1_reg <= '0;
            r2_reg <= '0;
            r3_reg <= '0;
        end else if (clear) begin
            r1_reg <= '0;
            r2_reg <= '0;
            r3_reg <= '0;
        end else begin
            r1_reg <= r1_next;
            r2_reg <= r2_next;
            r3_reg <= r3_next;
        end
    end

endmodule

// File: rtl/a51_stream_decrypt.sv
// A5/1 stream decryptor: key/frame setup, warm-up, then 8 keystream bits per
// ciphertext byte, XORed into a registered valid/ready output.
// Optional feature macro: A51_ABORT_EN adds a synchronous abort input that
// returns the block to IDLE and clears the frame.
module a51_stream_decrypt
    import a51_pkg::*;
#(
    parameter int MSG_BYTES  = 28,
    parameter int WARMUP_CYC = 100
) (
    input  logic                               clk,
    input  logic                               reset,
`ifdef A51_ABORT_EN
    input  logic                               abort,
`endif
    input  logic [63:0]                        key,
    input  logic [21:0]                        frame,
    input  logic                               start,
    output logic                               busy,
    input  logic [7:0]                         in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [7:0]                         out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [$clog2(MSG_BYTES+1)-1:0]     byte_count,
    output logic                               done
);

    localparam int BC_W      = $clog2(MSG_BYTES + 1);
    localparam int PHASE_MAX = (WARMUP_CYC > KEY_BITS) ? WARMUP_CYC : KEY_BITS;
    localparam int PHASE_W   = $clog2(PHASE_MAX);

    a51_state_t        state_reg, state_next;
    logic [PHASE_W-1:0] phase_reg;
    logic [63:0]       key_reg;
    logic [21:0]       frame_reg;
    logic [7:0]        ks_byte_reg;
    logic [7:0]        out_data_reg;
    logic              out_valid_reg;
    logic [BC_W-1:0]   byte_count_reg;

    lfsr_mode_t        core_mode;
    logic              core_load_bit;
    logic              core_clear;
    logic              core_ks_bit;
    logic              start_acc;
    logic              accept;
    logic              abort_req;

`ifdef A51_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign in_ready = (state_reg == XFER) & (~out_valid_reg | out_ready);
    assign accept   = in_valid & in_ready;

    a51_lfsr_core u_core (
        .clk      (clk),
        .reset    (reset),
        .clear    (core_clear),
        .mode     (core_mode),
        .load_bit (core_load_bit),
        .ks_bit   (core_ks_bit)
    );

    // Next-state and core control; abort overrides everything, including start.
    always_comb begin
        state_next    = state_reg;
        core_mode     = MODE_HOLD;
        core_load_bit = 1'b0;
        core_clear    = 1'b0;
        start_acc     = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    start_acc  = 1'b1;
                    core_clear = 1'b1;
                    state_next = LOAD_KEY;
                end
            end
            LOAD_KEY: begin
                core_mode     = MODE_LOAD;
                core_load_bit = key_reg[phase_reg[5:0]];
                if (phase_reg == PHASE_W'(KEY_BITS - 1)) state_next = LOAD_FRAME;
            end
            LOAD_FRAME: begin
                core_mode     = MODE_LOAD;
                core_load_bit = frame_reg[phase_reg[4:0]];
                if (phase_reg == PHASE_W'(FRAME_BITS - 1)) state_next = WARMUP;
            end
            WARMUP: begin
                core_mode = MODE_MAJ;
                if (phase_reg == PHASE_W'(WARMUP_CYC - 1)) state_next = GEN;
            end
            GEN: begin
                core_mode = MODE_MAJ;
                if (phase_reg == PHASE_W'(GEN_BITS - 1)) state_next = XFER;
            end
            XFER: begin
                if (accept) begin
                    state_next = (byte_count_reg == BC_W'(MSG_BYTES - 1)) ? DONE : GEN;
                end
            end
            default: state_next = IDLE;
        endcase
        if (abort_req) begin
            state_next = IDLE;
            core_mode  = MODE_HOLD;
            core_clear = 1'b1;
            start_acc  = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Phase counter, key/frame latch, keystream byte shifter and output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_reg      <= '0;
            key_reg        <= '0;
            frame_reg      <= '0;
            ks_byte_reg    <= '0;
            out_data_reg   <= '0;
            out_valid_reg  <= 1'b0;
            byte_count_reg <= '0;
        end else begin
            phase_reg <= (state_next != state_reg) ? '0 : phase_reg + 1'b1;
            if (start_acc) begin
                key_reg   <= key;
                frame_reg <= frame;
            end
            if (state_reg == GEN) ks_byte_reg <= {ks_byte_reg[6:0], core_ks_bit};
            if (abort_req) begin
                out_valid_reg  <= 1'b0;
                byte_count_reg <= '0;
            end else begin
                if (accept) begin
                    out_data_reg   <= in_data ^ ks_byte_reg;
                    out_valid_reg  <= 1'b1;
                    byte_count_reg <= byte_count_reg + 1'b1;
                end else if (out_ready) begin
                    out_valid_reg <= 1'b0;
                end
                if (start_acc) byte_count_reg <= '0;
            end
        end
    end

    assign busy       = (state_reg != IDLE) & (state_reg != DONE);
    assign done       = (state_reg == DONE) & ~out_valid_reg;
    assign out_data   = out_data_reg;
    assign out_valid  = out_valid_reg;
    assign byte_count = byte_count_reg;

endmodule

// File: tb/tb_a51_stream_decrypt.sv
// Self-checking bench for a51_stream_decrypt: a bit-array A5/1 model builds the
// frame keystream; a negedge monitor checks every output handshake against it.
module tb_a51_stream_decrypt;

    localparam int MSG_BYTES  = 28;
    localparam int WARMUP_CYC = 100;
    localparam logic [63:0] K1 = 64'hEFCDAB8967452312;
    localparam logic [21:0] F1 = 22'h134;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        abort = 1'b0;
    logic [63:0] key = '0;
    logic [21:0] frame = '0;
    logic        start = 1'b0;
    logic        busy;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  byte_count;
    logic        done;

    always #5 clk = ~clk;

    a51_stream_decrypt #(.MSG_BYTES(MSG_BYTES), .WARMUP_CYC(WARMUP_CYC)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef A51_ABORT_EN
        .abort      (abort),
`endif
        .key        (key),
        .frame      (frame),
        .start      (start),
        .busy       (busy),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .byte_count (byte_count),
        .done       (done)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // ---------------- reference model (plain bit arrays) ----------------
    int rl [3]    = '{19, 22, 23};
    int rc [3]    = '{8, 10, 10};
    int rt [3][4] = '{'{18, 17, 16, 13}, '{21, 20, -1, -1}, '{22, 21, 20, 7}};
    bit st [3][23];
    logic [7:0] ks_model [MSG_BYTES];

    function automatic bit fbk(input int n);
        bit x = 1'b0;
        for (int t = 0; t < 4; t++) if (rt[n][t] >= 0) x ^= st[n][rt[n][t]];
        return x;
    endfunction

    task automatic step(input int n, input bit inb);
        for (int j = rl[n] - 1; j > 0; j--) st[n][j] = st[n][j-1];
        st[n][0] = inb;
    endtask

    task automatic clk_all(input bit x);
        for (int n = 0; n < 3; n++) step(n, fbk(n) ^ x);
    endtask

    task automatic clk_maj();
        int ones = 0;
        bit m;
        for (int n = 0; n < 3; n++) ones += int'(st[n][rc[n]]);
        m = (ones >= 2);
        for (int n = 0; n < 3; n++) if (st[n][rc[n]] == m) step(n, fbk(n));
    endtask

    function automatic bit ks_out();
        return st[0][rl[0]-1] ^ st[1][rl[1]-1] ^ st[2][rl[2]-1];
    endfunction

    task automatic build_model(input logic [63:0] k, input logic [21:0] f);
        logic [7:0] b;
        for (int n = 0; n < 3; n++) for (int j = 0; j < 23; j++) st[n][j] = 1'b0;
        for (int i = 0; i < 64; i++) clk_all(k[i]);
        for (int i = 0; i < 22; i++) clk_all(f[i]);
        for (int i = 0; i < WARMUP_CYC; i++) clk_maj();
        for (int by = 0; by < MSG_BYTES; by++) begin
            b = 8'h00;
            for (int i = 0; i < 8; i++) begin
                clk_maj();
                b = {b[6:0], ks_out()};
            end
            ks_model[by] = b;
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [7:0] exp_q [$];
    logic [7:0] got [$];
    int         acc_idx = 0;
    logic [7:0] mon_exp;

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                chk("out_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    chk("out_data", out_data, mon_exp);
                    chk("byte_count_at_out", byte_count, acc_idx);
                    got.push_back(out_data);
                    $display("out byte %0d: data=%02h count=%0d", got.size(), out_data, byte_count);
                end
            end
            if (in_valid && in_ready) begin
                chk("accept_within_frame", acc_idx < MSG_BYTES, 1);
                if (acc_idx < MSG_BYTES) exp_q.push_back(in_data ^ ks_model[acc_idx]);
                acc_idx++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic model_reset();
        exp_q.delete();
        got.delete();
        acc_idx = 0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #2;
        reset = 1'b1; in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic start_frame(input logic [63:0] k, input logic [21:0] f);
        build_model(k, f);
        @(posedge clk); #1;
        key = k; frame = f; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; acc_idx = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int c = 0;
        bit ok = 1'b0;
        @(posedge clk); #1;
        in_data = b; in_valid = 1'b1;
        while (!ok && c < 400) begin
            @(negedge clk); c++;
            if (in_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("in_accept", ok, 1);
    endtask

    task automatic wait_out(input int n);
        int c = 0;
        while (got.size() < n && c < 2000) begin @(negedge clk); c++; end
        chk("out_count", got.size(), n);
    endtask

    task automatic reset_check(input string tag);
        #3 reset = 1'b1;
        #1;
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_byte_count"}, byte_count, 0);
        chk({tag, "_done"}, done, 0);
        model_reset();
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic two_zero_bytes(input string tag);
        got.delete();
        send_byte(8'h00);
        send_byte(8'h00);
        wait_out(2);
        if (got.size() >= 2) begin
            chk({tag, "_byte0"}, got[0], 8'h53);
            chk({tag, "_byte1"}, got[1], 8'h4E);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string pt;
        int    cyc;
        int    first;
        int    c;
        bit    ok;

        pt = "HELLO A51 STREAM DECRYPT OK!";

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_byte_count", byte_count, 0);
        chk("rst_done", done, 0);

        // Pin the model against the published A5/1 vector
        build_model(K1, F1);
        chk("model_ks0", ks_model[0], 8'h53);
        chk("model_ks1", ks_model[1], 8'h4E);
        chk("model_ks2", ks_model[2], 8'hAA);
        chk("model_ks3", ks_model[3], 8'h58);

        // Test 1: two zero bytes give the raw keystream
        start_frame(K1, F1);
        two_zero_bytes("t1");

        // Test 2: full frame round trip
        apply_reset();
        start_frame(K1, F1);
        for (int i = 0; i < MSG_BYTES; i++) send_byte(pt[i] ^ ks_model[i]);
        wait_out(MSG_BYTES);
        for (int i = 0; i < MSG_BYTES && i < got.size(); i++) chk("t2_plaintext", got[i], pt[i]);
        repeat (2) @(posedge clk); #1;
        chk("t2_done", done, 1);
        chk("t2_byte_count", byte_count, MSG_BYTES);
        chk("t2_busy", busy, 0);

        // Test 3: output back-pressure, restart from DONE
        got.delete();
        start_frame(K1, F1);
        out_ready = 1'b0;
        send_byte(8'h11);
        in_data = 8'h22; in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("t3_out_data_held", out_data, 8'h11 ^ ks_model[0]);
            chk("t3_out_valid_held", out_valid, 1);
            chk("t3_in_ready_low", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        c = 0; ok = 1'b0;
        while (!ok && c < 9) begin
            @(negedge clk); c++;
            if (in_ready) ok = 1'b1;
        end
        chk("t3_release_accept", ok, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(2);

        // Test 4: start-to-ready latency, busy start ignored, early in_valid ignored
        apply_reset();
        build_model(K1, F1);
        @(posedge clk); #1;
        key = K1; frame = F1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; acc_idx = 0;
        chk("t4_busy", busy, 1);
        in_data = 8'h00; in_valid = 1'b1;
        cyc = 0; first = -1;
        while (first < 0 && cyc < 400) begin
            @(posedge clk); cyc++; #1;
            if (cyc == 50) begin key = ~K1; frame = 22'h3FFFFF; start = 1'b1; end
            else start = 1'b0;
            if (in_ready) first = cyc;
        end
        chk("t4_start_to_in_ready", first, 194);
        @(posedge clk); #1;
        in_valid = 1'b0; key = K1; frame = F1;
        send_byte(8'h00);
        wait_out(2);
        if (got.size() >= 2) begin
            chk("t4_byte0", got[0], 8'h53);
            chk("t4_byte1", got[1], 8'h4E);
        end

        // Test 5: reset during WARMUP and during XFER with a pending byte
        apply_reset();
        start_frame(K1, F1);
        repeat (120) @(posedge clk);
        chk("t5_busy_warmup", busy, 1);
        reset_check("t5_warmup");
        start_frame(K1, F1);
        out_ready = 1'b0;
        send_byte(8'h5A);
        repeat (3) @(posedge clk);
        chk("t5_pending", out_valid, 1);
        reset_check("t5_xfer");
        out_ready = 1'b1;
        start_frame(K1, F1);
        two_zero_bytes("t5");

`ifdef A51_ABORT_EN
        // Test 6: abort mid-frame, then restart
        apply_reset();
        start_frame(K1, F1);
        for (int i = 0; i < 5; i++) send_byte(8'h00);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        model_reset();
        chk("t6_busy", busy, 0);
        chk("t6_byte_count", byte_count, 0);
        chk("t6_out_valid", out_valid, 0);
        start_frame(K1, F1);
        two_zero_bytes("t6");
`endif

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
